// File: rtl/cmd_router_if.sv
// Command/response bus between core frontends, the router and its destinations.
// master = frontends + destinations (environment), slave = cmd_router.
interface cmd_router_if #(
    parameter int NUM_CORES     = 8,
    parameter int NUM_INTF      = 2,
    parameter int CMD_WIDTH     = 256,
    parameter int INTF_ID_WIDTH = 14,
    parameter int ID_WIDTH      = 2
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int ND = NUM_INTF + 1;

    logic [NUM_CORES-1:0]               core_cmd_valid_i;
    logic [NUM_CORES-1:0]               core_cmd_ready_o;
    logic [NUM_CORES*CMD_WIDTH-1:0]     core_cmd_data_i;
    logic [NUM_CORES-1:0]               core_cmd_to_uncluster_i;
    logic [NUM_CORES*INTF_ID_WIDTH-1:0] core_cmd_intf_id_i;
    logic [NUM_CORES*ID_WIDTH-1:0]      core_cmd_local_id_i;

    logic [ND-1:0]                      dst_cmd_valid_o;
    logic [ND-1:0]                      dst_cmd_ready_i;
    logic [CMD_WIDTH-1:0]               dst_cmd_data_o;
    logic [CW-1:0]                      dst_cmd_core_idx_o;
    logic [ID_WIDTH-1:0]                dst_cmd_local_id_o;

    logic [ND-1:0]                      dst_resp_valid_i;
    logic [ND-1:0]                      dst_resp_ready_o;
    logic [ND*CW-1:0]                   dst_resp_core_idx_i;
    logic [ND*ID_WIDTH-1:0]             dst_resp_local_id_i;

    logic [NUM_CORES-1:0]               core_resp_valid_o;
    logic [NUM_CORES*ID_WIDTH-1:0]      core_resp_local_id_o;

    modport master (
        output core_cmd_valid_i, core_cmd_data_i, core_cmd_to_uncluster_i,
               core_cmd_intf_id_i, core_cmd_local_id_i, dst_cmd_ready_i,
               dst_resp_valid_i, dst_resp_core_idx_i, dst_resp_local_id_i,
        input  core_cmd_ready_o, dst_cmd_valid_o, dst_cmd_data_o, dst_cmd_core_idx_o,
               dst_cmd_local_id_o, dst_resp_ready_o, core_resp_valid_o, core_resp_local_id_o
    );

    modport slave (
        input  core_cmd_valid_i, core_cmd_data_i, core_cmd_to_uncluster_i,
               core_cmd_intf_id_i, core_cmd_local_id_i, dst_cmd_ready_i,
               dst_resp_valid_i, dst_resp_core_idx_i, dst_resp_local_id_i,
        output core_cmd_ready_o, dst_cmd_valid_o, dst_cmd_data_o, dst_cmd_core_idx_o,
               dst_cmd_local_id_o, dst_resp_ready_o, core_resp_valid_o, core_resp_local_id_o
    );
endinterface

// File: rtl/cmd_router.sv
// Round-robin command router from core frontends to local units / uncluster, with response return.
// Latency: command 1 cycle (registered, no bypass); response 1 cycle, pulsed per core.
// Backpressure: core ready only when the output register can take a word; losing responders stall.
module cmd_router #(
    parameter int NUM_CORES     = 8,
    parameter int NUM_INTF      = 2,
    parameter int CMD_WIDTH     = 256,
    parameter int INTF_ID_WIDTH = 14,
    parameter int ID_WIDTH      = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    cmd_router_if.slave bus
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int ND = NUM_INTF + 1;
    localparam int DW = (ND > 1) ? $clog2(ND) : 1;

    typedef struct packed {
        logic [CMD_WIDTH-1:0] data;
        logic [CW-1:0]        core_idx;
        logic [ID_WIDTH-1:0]  local_id;
        logic [DW-1:0]        dst;
    } cmd_t;

    typedef struct packed {
        logic [CW-1:0]       core_idx;
        logic [ID_WIDTH-1:0] local_id;
    } err_t;

    logic [CW-1:0]        rr_ptr;
    logic                 out_full;
    cmd_t                 out_q;
    logic                 err_full;
    err_t                 err_q;

    logic [NUM_CORES-1:0] cand_invalid;
    logic [NUM_CORES-1:0] eligible;
    logic                 gnt_any;
    logic [CW-1:0]        gnt_idx;
    int                   scan_idx;
    logic                 can_accept;
    logic                 dst_hs;
    logic                 core_hs;
    logic                 gnt_invalid;
    logic [ND-1:0]        dst_valid;
    cmd_t                 new_cmd;

    logic [NUM_CORES-1:0]               resp_sel;
    logic [NUM_CORES-1:0][ID_WIDTH-1:0] resp_id;
    logic [ND-1:0]                      resp_rdy;
    logic [CW-1:0]                      src_core;
    logic [NUM_CORES-1:0]               core_resp_valid_q;
    logic [NUM_CORES-1:0][ID_WIDTH-1:0] core_resp_id_q;

    // A command is invalid when it targets a local unit index that does not exist.
    always_comb begin
        cand_invalid = '0;
        eligible     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand_invalid[k] = !bus.core_cmd_to_uncluster_i[k] &&
                (bus.core_cmd_intf_id_i[k*INTF_ID_WIDTH +: INTF_ID_WIDTH] >= INTF_ID_WIDTH'(NUM_INTF));
            eligible[k] = bus.core_cmd_valid_i[k] && !(cand_invalid[k] && err_full);
        end
    end

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_CORES;
            if (!gnt_any && eligible[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CW'(scan_idx);
            end
        end
    end

    assign dst_valid   = out_full ? (ND'(1) << out_q.dst) : '0;
    assign dst_hs      = |(dst_valid & bus.dst_cmd_ready_i);
    assign can_accept  = !out_full || dst_hs;
    assign core_hs     = gnt_any && can_accept;
    assign gnt_invalid = cand_invalid[gnt_idx];

    always_comb begin
        new_cmd          = '0;
        new_cmd.data     = bus.core_cmd_data_i[int'(gnt_idx)*CMD_WIDTH +: CMD_WIDTH];
        new_cmd.core_idx = gnt_idx;
        new_cmd.local_id = bus.core_cmd_local_id_i[int'(gnt_idx)*ID_WIDTH +: ID_WIDTH];
        new_cmd.dst      = bus.core_cmd_to_uncluster_i[gnt_idx] ? DW'(NUM_INTF) :
                           bus.core_cmd_intf_id_i[int'(gnt_idx)*INTF_ID_WIDTH +: DW];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            out_full <= 1'b0;
            out_q    <= '0;
            err_full <= 1'b0;
            err_q    <= '0;
        end else begin
            if (core_hs) begin
                rr_ptr <= (gnt_idx == CW'(NUM_CORES-1)) ? '0 : gnt_idx + CW'(1);
            end
            if (core_hs && !gnt_invalid) begin
                out_full <= 1'b1;
                out_q    <= new_cmd;
            end else if (dst_hs) begin
                out_full <= 1'b0;
            end
            // The error entry has top response priority, so it always drains the cycle after capture.
            if (core_hs && gnt_invalid) begin
                err_full       <= 1'b1;
                err_q.core_idx <= gnt_idx;
                err_q.local_id <= new_cmd.local_id;
            end else if (err_full) begin
                err_full <= 1'b0;
            end
        end
    end

    assign bus.core_cmd_ready_o   = core_hs ? (NUM_CORES'(1) << gnt_idx) : '0;
    assign bus.dst_cmd_valid_o    = dst_valid;
    assign bus.dst_cmd_data_o     = out_q.data;
    assign bus.dst_cmd_core_idx_o = out_q.core_idx;
    assign bus.dst_cmd_local_id_o = out_q.local_id;

    // Per core: error entry first, then the lowest-index destination aimed at it.
    always_comb begin
        resp_sel = '0;
        resp_id  = '0;
        resp_rdy = '0;
        src_core = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (err_full && (err_q.core_idx == CW'(c))) begin
                resp_sel[c] = 1'b1;
                resp_id[c]  = err_q.local_id;
            end
        end
        for (int s = 0; s < ND; s++) begin
            src_core = bus.dst_resp_core_idx_i[s*CW +: CW];
            if (bus.dst_resp_valid_i[s] && !resp_sel[src_core]) begin
                resp_sel[src_core] = 1'b1;
                resp_id[src_core]  = bus.dst_resp_local_id_i[s*ID_WIDTH +: ID_WIDTH];
                resp_rdy[s]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_resp_valid_q <= '0;
            core_resp_id_q    <= '0;
        end else begin
            core_resp_valid_q <= resp_sel;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (resp_sel[c]) begin
                    core_resp_id_q[c] <= resp_id[c];
                end
            end
        end
    end

    assign bus.dst_resp_ready_o     = resp_rdy;
    assign bus.core_resp_valid_o    = core_resp_valid_q;
    assign bus.core_resp_local_id_o = core_resp_id_q;
endmodule

// File: tb/tb_cmd_router.sv
// Directed-vector bench for cmd_router: stimulus pushes expected commands/responses into
// queues, independent negedge monitors pop and compare when the DUT presents them.
module tb_cmd_router;
    localparam int NC = 8;
    localparam int NI = 2;
    localparam int CWD = 256;
    localparam int IIW = 14;
    localparam int IDW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nchecks = 0;
    int   nfail = 0;
    bit   head_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_router_if #(.NUM_CORES(NC), .NUM_INTF(NI), .CMD_WIDTH(CWD),
                    .INTF_ID_WIDTH(IIW), .ID_WIDTH(IDW)) bus ();

    cmd_router #(.NUM_CORES(NC), .NUM_INTF(NI), .CMD_WIDTH(CWD),
                 .INTF_ID_WIDTH(IIW), .ID_WIDTH(IDW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]     vld;
        int             core;
        int             lid;
        logic [255:0]   data;
        int             cyc;
    } exp_cmd_t;

    typedef struct {
        int core;
        int lid;
        int cyc;
    } exp_resp_t;

    exp_cmd_t  cmd_q[$];
    exp_resp_t resp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        nchecks++;
        nfail++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [255:0] mk(input int core, input int lid);
        logic [31:0] w;
        w = 32'hA500_0000 | 32'(core << 8) | 32'(lid);
        return {8{w}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_core(input int k, input bit v, input bit unc, input int iid, input int lid);
        bus.core_cmd_valid_i[k]                 = v;
        bus.core_cmd_to_uncluster_i[k]          = unc;
        bus.core_cmd_intf_id_i[k*IIW +: IIW]    = IIW'(iid);
        bus.core_cmd_local_id_i[k*IDW +: IDW]   = IDW'(lid);
        bus.core_cmd_data_i[k*CWD +: CWD]       = mk(k, lid);
    endtask

    task automatic set_resp(input int s, input bit v, input int core, input int lid);
        bus.dst_resp_valid_i[s]                 = v;
        bus.dst_resp_core_idx_i[s*CW +: CW]     = CW'(core);
        bus.dst_resp_local_id_i[s*IDW +: IDW]   = IDW'(lid);
    endtask

    task automatic push_cmd(input int dst, input int core, input int lid, input int at);
        exp_cmd_t e;
        e.vld  = 3'(1 << dst);
        e.core = core;
        e.lid  = lid;
        e.data = mk(core, lid);
        e.cyc  = at;
        cmd_q.push_back(e);
    endtask

    task automatic push_resp(input int core, input int lid, input int at);
        exp_resp_t e;
        e.core = core;
        e.lid  = lid;
        e.cyc  = at;
        resp_q.push_back(e);
    endtask

    // Command monitor: peeks the head every valid cycle (stability), pops on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            head_seen = 1'b0;
        end else if (bus.dst_cmd_valid_o != 3'b000) begin
            if (cmd_q.size() == 0) begin
                fail("cmd_unexpected", int'(bus.dst_cmd_valid_o), 0);
            end else begin
                chk("cmd_dst", bus.dst_cmd_valid_o, cmd_q[0].vld);
                chk("cmd_core", bus.dst_cmd_core_idx_o, cmd_q[0].core);
                chk("cmd_lid", bus.dst_cmd_local_id_o, cmd_q[0].lid);
                chk("cmd_data", bus.dst_cmd_data_o, cmd_q[0].data);
                if (!head_seen) chk("cmd_cycle", cyc, cmd_q[0].cyc);
                head_seen = 1'b1;
                if ((bus.dst_cmd_valid_o & bus.dst_cmd_ready_i) != 3'b000) begin
                    void'(cmd_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Response monitor: every pulse must match the oldest expectation for that core.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int c = 0; c < NC; c++) begin
                if (bus.core_resp_valid_o[c]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < resp_q.size(); i++)
                        if (idx < 0 && resp_q[i].core == c) idx = i;
                    if (idx < 0) begin
                        fail("resp_unexpected", c, -1);
                    end else begin
                        chk("resp_lid", bus.core_resp_local_id_o[c*IDW +: IDW], resp_q[idx].lid);
                        chk("resp_cycle", cyc, resp_q[idx].cyc);
                        resp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int order[3];
        bus.core_cmd_valid_i        = '0;
        bus.core_cmd_data_i         = '0;
        bus.core_cmd_to_uncluster_i = '0;
        bus.core_cmd_intf_id_i      = '0;
        bus.core_cmd_local_id_i     = '0;
        bus.dst_cmd_ready_i         = '0;
        bus.dst_resp_valid_i        = '0;
        bus.dst_resp_core_idx_i     = '0;
        bus.dst_resp_local_id_i     = '0;

        // Reset state
        @(negedge clk);
        chk("rst_core_ready", bus.core_cmd_ready_o, 0);
        chk("rst_dst_valid", bus.dst_cmd_valid_o, 0);
        chk("rst_dst_data", bus.dst_cmd_data_o, 0);
        chk("rst_dst_idx", bus.dst_cmd_core_idx_o, 0);
        chk("rst_dst_lid", bus.dst_cmd_local_id_o, 0);
        chk("rst_resp_ready", bus.dst_resp_ready_o, 0);
        chk("rst_resp_valid", bus.core_resp_valid_o, 0);
        chk("rst_resp_lid", bus.core_resp_local_id_o, 0);
        step();
        rst_n = 1'b1;
        step();

        // Cores 0, 3, 5 to intf 0: granted in round-robin order, one per cycle
        order = '{0, 3, 5};
        bus.dst_cmd_ready_i = 3'b111;
        for (int i = 0; i < 3; i++) set_core(order[i], 1'b1, 1'b0, 0, i + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rr_grant", bus.core_cmd_ready_o, 8'(1 << order[i]));
            push_cmd(0, order[i], i + 1, cyc + 1);
            step();
            bus.core_cmd_valid_i[order[i]] = 1'b0;
        end

        // Pointer now 6: core 7 beats core 0
        set_core(0, 1'b1, 1'b0, 1, 0);
        set_core(7, 1'b1, 1'b0, 1, 1);
        @(negedge clk);
        chk("ptr6_grant7", bus.core_cmd_ready_o, 8'h80);
        push_cmd(1, 7, 1, cyc + 1);
        step();
        bus.core_cmd_valid_i[7] = 1'b0;
        @(negedge clk);
        chk("ptr_wrap_grant0", bus.core_cmd_ready_o, 8'h01);
        push_cmd(1, 0, 0, cyc + 1);
        step();
        bus.core_cmd_valid_i[0] = 1'b0;

        // Uncluster command held while its destination stalls for 4 cycles
        idle(2);
        bus.dst_cmd_ready_i = 3'b011;
        set_core(2, 1'b1, 1'b1, 0, 3);
        @(negedge clk);
        chk("unc_grant", bus.core_cmd_ready_o, 8'h04);
        push_cmd(2, 2, 3, cyc + 1);
        step();
        bus.core_cmd_valid_i[2] = 1'b0;
        set_core(6, 1'b1, 1'b0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_no_grant", bus.core_cmd_ready_o, 8'h00);
            chk("stall_dst_valid", bus.dst_cmd_valid_o, 3'b100);
            step();
        end
        bus.dst_cmd_ready_i = 3'b111;
        @(negedge clk);
        chk("unstall_grant6", bus.core_cmd_ready_o, 8'h40);
        push_cmd(0, 6, 1, cyc + 1);
        step();
        bus.core_cmd_valid_i[6] = 1'b0;

        // Invalid commands: absorbed, self-completed; a second one waits a cycle
        idle(3);
        set_core(1, 1'b1, 1'b0, 7, 2);
        set_core(4, 1'b1, 1'b0, 9, 1);
        @(negedge clk);
        chk("inv_grant1", bus.core_cmd_ready_o, 8'h02);
        push_resp(1, 2, cyc + 2);
        step();
        bus.core_cmd_valid_i[1] = 1'b0;
        set_core(5, 1'b1, 1'b0, 1, 2);
        @(negedge clk);
        chk("inv_withheld", bus.core_cmd_ready_o, 8'h20);
        chk("inv_no_dst", bus.dst_cmd_valid_o, 3'b000);
        push_cmd(1, 5, 2, cyc + 1);
        step();
        bus.core_cmd_valid_i[5] = 1'b0;
        @(negedge clk);
        chk("inv_grant4", bus.core_cmd_ready_o, 8'h10);
        push_resp(4, 1, cyc + 2);
        step();
        bus.core_cmd_valid_i[4] = 1'b0;

        // Boundary intf_id == NUM_INTF is invalid; its completion outranks a destination
        idle(4);
        set_core(3, 1'b1, 1'b0, NI, 0);
        @(negedge clk);
        chk("bnd_grant3", bus.core_cmd_ready_o, 8'h08);
        push_resp(3, 0, cyc + 2);
        step();
        bus.core_cmd_valid_i[3] = 1'b0;
        set_resp(0, 1'b1, 3, 3);
        @(negedge clk);
        chk("err_prio_rdy", bus.dst_resp_ready_o, 3'b000);
        step();
        @(negedge clk);
        chk("err_prio_rdy2", bus.dst_resp_ready_o, 3'b001);
        push_resp(3, 3, cyc + 1);
        step();
        set_resp(0, 1'b0, 0, 0);

        // Two destinations to core 4: lowest index first
        idle(2);
        set_resp(0, 1'b1, 4, 1);
        set_resp(2, 1'b1, 4, 0);
        @(negedge clk);
        chk("resp_prio_rdy", bus.dst_resp_ready_o, 3'b001);
        push_resp(4, 1, cyc + 1);
        step();
        set_resp(0, 1'b0, 0, 0);
        @(negedge clk);
        chk("resp_prio_rdy2", bus.dst_resp_ready_o, 3'b100);
        push_resp(4, 0, cyc + 1);
        step();
        set_resp(2, 1'b0, 0, 0);

        // Cores 0 and 7 served in the same cycle; IDs hold afterwards
        idle(1);
        set_resp(1, 1'b1, 0, 2);
        set_resp(2, 1'b1, 7, 3);
        @(negedge clk);
        chk("dual_rdy", bus.dst_resp_ready_o, 3'b110);
        push_resp(0, 2, cyc + 1);
        push_resp(7, 3, cyc + 1);
        step();
        set_resp(1, 1'b0, 0, 0);
        set_resp(2, 1'b0, 0, 0);
        step();
        @(negedge clk);
        chk("hold_valid", bus.core_resp_valid_o, 8'h00);
        chk("hold_lid7", bus.core_resp_local_id_o[7*IDW +: IDW], 2'd3);
        chk("hold_lid0", bus.core_resp_local_id_o[0 +: IDW], 2'd2);

        // Reset with the output register full and a response in selection
        idle(2);
        bus.dst_cmd_ready_i = 3'b101;
        set_core(2, 1'b1, 1'b0, 1, 1);
        @(negedge clk);
        chk("pre_rst_grant", bus.core_cmd_ready_o, 8'h04);
        push_cmd(1, 2, 1, cyc + 1);
        step();
        bus.core_cmd_valid_i[2] = 1'b0;
        chk("pre_rst_dst_valid", bus.dst_cmd_valid_o, 3'b010);
        set_resp(0, 1'b1, 5, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dst_valid", bus.dst_cmd_valid_o, 3'b000);
        cmd_q.delete();
        set_resp(0, 1'b0, 0, 0);
        bus.dst_cmd_ready_i = 3'b111;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", bus.core_resp_valid_o, 8'h00);
            chk("post_rst_no_cmd", bus.dst_cmd_valid_o, 3'b000);
            step();
        end
        chk("post_rst_lid", bus.core_resp_local_id_o, 0);

        // Pointer back at 0: core 1 before core 7
        set_core(1, 1'b1, 1'b0, 0, 1);
        set_core(7, 1'b1, 1'b0, 0, 2);
        @(negedge clk);
        chk("ptr0_grant1", bus.core_cmd_ready_o, 8'h02);
        push_cmd(0, 1, 1, cyc + 1);
        step();
        bus.core_cmd_valid_i[1] = 1'b0;
        @(negedge clk);
        chk("ptr0_grant7", bus.core_cmd_ready_o, 8'h80);
        push_cmd(0, 7, 2, cyc + 1);
        step();
        bus.core_cmd_valid_i[7] = 1'b0;

        for (int i = 0; i < 50 && (cmd_q.size() != 0 || resp_q.size() != 0); i++) step();
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
